// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential BCD-to-binary converter using reverse double dabble. Each clock
// in RUN shifts the working register {d3,d2,d1,d0,acc[13:0]} right by one bit.
// Then every BCD digit that is >= 8 has 3 subtracted from it. After 14 steps
// acc holds the binary value of the four-digit decimal input.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous, active-low reset
//   start      in   1   conversion request, sampled on the rising edge
//   thousands  in   4   BCD digit d3, sampled only on the accepting edge
//   hundreds   in   4   BCD digit d2
//   tens       in   4   BCD digit d1
//   ones       in   4   BCD digit d0
//   bin        out  14  registered result, held until the next result
//   busy       out  1   high while a conversion is shifting (RUN)
//   done       out  1   one-cycle pulse; bin/err are valid from this cycle on
//   err        out  1   invalid digit (>9) seen on the accepted load
//
// Handshake: start is accepted on any rising edge where the FSM is in IDLE or
// DONE. It has no ready signal. A start seen while busy is dropped, not queued.
// done pulses once per accepted start that is not aborted by reset.
//
// Optional feature, macro BCD2BIN_RANGE_CHECK_EN:
//   When defined, a load containing a digit > 9 skips the shifting. The
//   block then reports bin=0 and err=1 one cycle later, and busy stays low.
//   When undefined, err is tied low and any digit is converted as given.
//
// The FSM state is visible to a checker as the internal signal `state`.
// ---------------------------------------------------------------------------
module bcd_to_bin_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  thousands,
    input  logic [3:0]  hundreds,
    input  logic [3:0]  tens,
    input  logic [3:0]  ones,
    output logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // S_FAULT is the one-cycle hop used to report an invalid load.
    // It can only be reached when the range check is built in.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [29:0] work;
    logic [29:0] work_nxt;
    logic [29:0] shifted;
    logic [29:0] stepped;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [13:0] bin_nxt;
    logic        digits_bad;

    // Reverse-dabble correction for one 4-bit digit after the shift.
    function automatic logic [3:0] adjust(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

`ifdef BCD2BIN_RANGE_CHECK_EN
    logic err_q;
    logic err_nxt;

    assign digits_bad = (thousands > 4'd9) || (hundreds > 4'd9) ||
                        (tens > 4'd9) || (ones > 4'd9);
    assign err = err_q;
`else
    assign digits_bad = 1'b0;
    assign err        = 1'b0;
`endif

    // One algorithm step. The digits are corrected independently, and no
    // borrow passes between them.
    always_comb begin
        shifted = work >> 1;
        stepped = {adjust(shifted[29:26]), adjust(shifted[25:22]),
                   adjust(shifted[21:18]), adjust(shifted[17:14]),
                   shifted[13:0]};
    end

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        bin_nxt   = bin;
`ifdef BCD2BIN_RANGE_CHECK_EN
        err_nxt   = err_q;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (digits_bad) begin
                        work_nxt  = '0;
                        cnt_nxt   = 4'd0;
                        state_nxt = S_FAULT;
                    end else begin
                        work_nxt  = {thousands, hundreds, tens, ones, 14'd0};
                        cnt_nxt   = 4'd0;
                        state_nxt = S_RUN;
                    end
                end else if (state == S_DONE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                work_nxt = stepped;
                cnt_nxt  = cnt + 4'd1;
                // The 14th shift completes here. Publish the post-shift acc.
                if (cnt == 4'd13) begin
                    bin_nxt   = stepped[13:0];
`ifdef BCD2BIN_RANGE_CHECK_EN
                    err_nxt   = 1'b0;
`endif
                    state_nxt = S_DONE;
                end
            end
            S_FAULT: begin
                bin_nxt   = 14'd0;
`ifdef BCD2BIN_RANGE_CHECK_EN
                err_nxt   = 1'b1;
`endif
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            work  <= '0;
            cnt   <= 4'd0;
            bin   <= 14'd0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            cnt   <= cnt_nxt;
            bin   <= bin_nxt;
        end
    end

`ifdef BCD2BIN_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
        end
    end
`endif

    // Both flags are decoded straight from the state register.
    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//
// Directed bench for bcd_to_bin_seq. The expected result of each conversion
// is the decimal weighted sum of its digits, or 0 with err set for a rejected
// load. It is pushed to a queue when start is driven and popped when done
// pulses. Inputs are driven and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  thousands;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [13:0] exp_q[$];
    logic        exp_err_q[$];

    bcd_to_bin_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d,
                            input logic e);
        int v;
        v = a * 1000 + b * 100 + c * 10 + d;
        exp_q.push_back(e ? 14'd0 : 14'(v));
        exp_err_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        logic [13:0] eb;
        logic        ee;
        if (exp_q.size() == 0) begin
            check({tag, " queue_empty"}, 32'd1, 32'd0);
        end else begin
            eb = exp_q.pop_front();
            ee = exp_err_q.pop_front();
            check({tag, " bin"}, 32'(bin), 32'(eb));
            check({tag, " err"}, 32'(err), 32'(ee));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_start(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
        start     = 1'b1;
        thousands = a;
        hundreds  = b;
        tens      = c;
        ones      = d;
    endtask

    task automatic scramble_digits();
        thousands = 4'($urandom_range(0, 15));
        hundreds  = 4'($urandom_range(0, 15));
        tens      = 4'($urandom_range(0, 15));
        ones      = 4'($urandom_range(0, 15));
    endtask

    // Called on the falling edge right after the accepting edge N.
    // It counts edges until done is seen and checks busy on every cycle.
    task automatic wait_done(input string tag, input int exp_lat);
        int c;
        c = 0;
        while (!done && c < 40) begin
            check({tag, " busy_during"}, 32'(busy), (exp_lat == 14) ? 32'd1 : 32'd0);
            @(negedge clk);
            c++;
        end
        check({tag, " latency"}, 32'(c), 32'(exp_lat));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        pop_check(tag);
    endtask

    task automatic conv(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d,
                        input string tag, input int exp_lat, input logic exp_e);
        @(negedge clk);
        drive_start(a, b, c, d);
        push_exp(a, b, c, d, exp_e);
        @(negedge clk);
        start = 1'b0;
        scramble_digits();
        wait_done(tag, exp_lat);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        thousands = 4'd0;
        hundreds  = 4'd0;
        tens      = 4'd0;
        ones      = 4'd0;
        #2;
        check("reset bin",  32'(bin),  32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err",  32'(err),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        conv(4'd9, 4'd9, 4'd9, 4'd9, "d9999", 14, 1'b0);
        conv(4'd0, 4'd0, 4'd0, 4'd0, "d0000", 14, 1'b0);
        conv(4'd8, 4'd1, 4'd9, 4'd1, "d8191", 14, 1'b0);
        conv(4'd0, 4'd0, 4'd1, 4'd0, "d0010", 14, 1'b0);

`ifdef BCD2BIN_RANGE_CHECK_EN
        conv(4'd1, 4'd2, 4'hA, 4'd4, "bad_digit", 1, 1'b1);
`else
        conv(4'd1, 4'd2, 4'hA, 4'd4, "bad_digit", 14, 1'b0);
`endif
        conv(4'd0, 4'd0, 4'd0, 4'd1, "d0001", 14, 1'b0);

        // Back to back: start stays high through RUN and DONE.
        @(negedge clk);
        drive_start(4'd1, 4'd2, 4'd3, 4'd4);
        push_exp(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        @(negedge clk);
        thousands = 4'd0;
        hundreds  = 4'd0;
        tens      = 4'd4;
        ones      = 4'd2;
        push_exp(4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
        wait_done("b2b_first", 14);
        @(negedge clk);
        start = 1'b0;
        scramble_digits();
        wait_done("b2b_second", 14);
        @(negedge clk);
        check("b2b done_one_cycle", 32'(done), 32'd0);

        // A start during RUN is ignored.
        @(negedge clk);
        drive_start(4'd5, 4'd5, 4'd5, 4'd5);
        push_exp(4'd5, 4'd5, 4'd5, 4'd5, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        drive_start(4'd1, 4'd1, 4'd1, 4'd1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                n++;
                pop_check("ignore_start");
            end
        end
        check("ignore_start done_count", 32'(n), 32'd1);

        // A reset in the middle of RUN aborts the conversion.
        @(negedge clk);
        drive_start(4'd7, 4'd0, 4'd0, 4'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset bin",  32'(bin),  32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset err",  32'(err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("midreset no_done", 32'(n), 32'd0);
        conv(4'd7, 4'd0, 4'd0, 4'd7, "d7007", 14, 1'b0);

        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter. It is the inverse of the team's combinational double-dabble binary-to-BCD block. It takes four BCD digits (0000-9999) and produces a 14-bit binary value using reverse double dabble: shift right, then subtract 3 from any digit >= 8, one bit per clock. It sits behind keypad/display front-ends where operators enter decimal values that downstream counters and comparators need in binary.

## Interface
- Parameters: none; widths fixed (4 digits, 14-bit result).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request conversion; sampled on rising edge
- `thousands`, `hundreds`, `tens`, `ones`  in  4 each  BCD digits; sampled only on the edge that accepts `start`
- `bin`  out  14  converted value, registered; held until next result
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse; `bin`/`err` valid from this cycle on
- `err`  out  1  invalid digit (>9) detected on the accepted load

## Operation
- Working register: 30 bits, {d3,d2,d1,d0,acc[13:0]}, plus a 4-bit step counter.
- FSM states:
  - IDLE: waiting for `start`.
  - RUN: shifting, 14 steps.
  - DONE: one cycle, `done`=1.
- IDLE or DONE, `start`=1: load digits into d3..d0, acc=0, counter=0, go to RUN. `start` in RUN is ignored; it is not queued.
- RUN, each edge:
  - Shift the whole 30-bit register right by 1.
  - Then, independently per digit, if digit >= 8, subtract 3 (4-bit, no carry between digits).
  - Increment the counter.
  - On the edge where the counter goes 13->14: copy acc (post-shift value) to `bin`, set `err`=0, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE, unless `start` is high, which reloads straight into RUN.
- Result range 0..9999 always fits 14 bits; no overflow case exists.
- `bin` and `err` change only on the edge that enters DONE.

## Timing
- Reset values (async, immediate): `bin`=0, `busy`=0, `done`=0, `err`=0; FSM=IDLE; working register and counter cleared.
- Reset asserted mid-RUN aborts the conversion. No `done` pulse is produced and the partial result is discarded.
- `start` accepted at edge N:
  - `busy`=1 after edge N.
  - Shifts occur at edges N+1..N+14.
  - `done`=1 and `busy`=0 after edge N+14, for one cycle.
- Latency from start edge to `done`: 14 cycles.
- Back-to-back throughput: one conversion per 15 cycles, using `start` held or re-asserted in DONE.
- `start` and `rst_n` low together: reset wins.
- Input digits may change freely after the accepting edge.

## Configuration
- `BCD2BIN_RANGE_CHECK_EN` defined:
  - On the accepting edge, any digit > 9 skips RUN and goes directly to DONE.
  - `bin`=0, `err`=1, `done` asserts after edge N+1 (latency 1).
  - `busy` stays 0 in this case.
- Not defined:
  - No check is made; `err` is tied 0.
  - Invalid digits run the normal 14-step algorithm and yield a deterministic but meaningless `bin`.

## Test plan
- Digits 9,9,9,9, `start` pulse at edge N -> `busy` high for cycles N+1..N+14; `done` one cycle after edge N+14; `bin`=14'd9999 (0x270F); `err`=0.
- Digits 0,0,0,0 -> `bin`=0 after 14 cycles. Digits 8,1,9,1 -> `bin`=0x1FFF. Digits 0,0,1,0 -> `bin`=10.
- 1,2,3,4 followed by `start` held through DONE with 0,0,4,2 -> `done` pulses 15 cycles apart; `bin`=1234, then 42.
- `start` re-pulsed with new digits during RUN of 5,5,5,5 -> ignored; `bin`=5555; exactly one `done`.
- `rst_n` low for 1 cycle at step 5 of a 7,0,0,7 conversion -> all outputs 0 immediately; no `done`; next `start` with 7,0,0,7 gives 7007.
- With `BCD2BIN_RANGE_CHECK_EN`, digits 1,2,A,4 -> `done` after edge N+1, `err`=1, `bin`=0. A following valid 0,0,0,1 clears `err` and gives `bin`=1. Without the macro, the same stimulus gives `err`=0 and latency 14.
